// File: rtl/burst_vector_compute_if.sv
// Host-control and memory-port bundle for burst_vector_compute.
// master = compute engine side, slave = host/memory side.
interface burst_vector_compute_if #(
  parameter int MEM_LEN_BITS   = 8,
  parameter int MEM_ADDR_BITS  = 64,
  parameter int MEM_DATA_BITS  = 64,
  parameter int HOST_DATA_BITS = 32
);
  logic                      launch;
  logic                      finish;
  logic [HOST_DATA_BITS-1:0] length;
  logic [HOST_DATA_BITS-1:0] addend;
  logic [MEM_ADDR_BITS-1:0]  inp_baddr;
  logic [MEM_ADDR_BITS-1:0]  out_baddr;
  logic                      mem_req_valid;
  logic                      mem_req_opcode;
  logic [MEM_LEN_BITS-1:0]   mem_req_len;
  logic [MEM_ADDR_BITS-1:0]  mem_req_addr;
  logic                      mem_wr_valid;
  logic [MEM_DATA_BITS-1:0]  mem_wr_bits;
  logic                      mem_rd_valid;
  logic [MEM_DATA_BITS-1:0]  mem_rd_bits;
  logic                      mem_rd_ready;

  modport master (
    input  launch, length, addend, inp_baddr, out_baddr,
    input  mem_rd_valid, mem_rd_bits,
    output finish, mem_req_valid, mem_req_opcode, mem_req_len,
    output mem_req_addr, mem_wr_valid, mem_wr_bits, mem_rd_ready
  );

  modport slave (
    output launch, length, addend, inp_baddr, out_baddr,
    output mem_rd_valid, mem_rd_bits,
    input  finish, mem_req_valid, mem_req_opcode, mem_req_len,
    input  mem_req_addr, mem_wr_valid, mem_wr_bits, mem_rd_ready
  );
endinterface

// File: rtl/burst_vector_compute.sv
// Burst read -> per-lane add -> burst write engine.
// Define BURST_VECTOR_SAT_EN for saturating (instead of wrapping) lane sums.
module burst_vector_compute #(
  parameter int MEM_LEN_BITS   = 8,
  parameter int MEM_ADDR_BITS  = 64,
  parameter int MEM_DATA_BITS  = 64,
  parameter int HOST_DATA_BITS = 32,
  parameter int LANE_BITS      = 8,
  parameter int BURST_BEATS    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  burst_vector_compute_if.master bus
);
  localparam int LANES  = MEM_DATA_BITS / LANE_BITS;
  localparam int CW     = $clog2(BURST_BEATS) + 1;
  localparam int WBYTES = MEM_DATA_BITS / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_DATA, S_WR_REQ, S_WR_DATA, S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [HOST_DATA_BITS-1:0] r_remaining;
  logic [LANE_BITS-1:0]      r_addend;
  logic [MEM_ADDR_BITS-1:0]  r_rd_ptr;
  logic [MEM_ADDR_BITS-1:0]  r_wr_ptr;
  logic [CW-1:0]             r_cnt;
  logic [MEM_DATA_BITS-1:0]  r_buf [BURST_BEATS];

  logic [CW-1:0]            w_n;
  logic [CW-1:0]            w_last;
  logic [CW-2:0]            w_idx;
  logic                     w_last_beat;
  logic                     w_rd_fire;
  logic [MEM_ADDR_BITS-1:0] w_step;
  logic [MEM_DATA_BITS-1:0] w_sum;

  function automatic logic [LANE_BITS-1:0] lane_add(
    input logic [LANE_BITS-1:0] a,
    input logic [LANE_BITS-1:0] b
  );
`ifdef BURST_VECTOR_SAT_EN
    logic [LANE_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[LANE_BITS] ? '1 : s[LANE_BITS-1:0];
`else
    return a + b;
`endif
  endfunction

  // Burst size is fixed by what remains at the start of each burst.
  always_comb begin
    if (r_remaining < HOST_DATA_BITS'(BURST_BEATS)) begin
      w_n = r_remaining[CW-1:0];
    end else begin
      w_n = CW'(BURST_BEATS);
    end
  end

  assign w_last      = w_n - CW'(1);
  assign w_idx       = r_cnt[CW-2:0];
  assign w_last_beat = (r_cnt == w_last);
  assign w_rd_fire   = (r_state == S_RD_DATA) && bus.mem_rd_valid;
  assign w_step      = MEM_ADDR_BITS'(w_n) * MEM_ADDR_BITS'(WBYTES);

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum[i*LANE_BITS +: LANE_BITS] =
        lane_add(bus.mem_rd_bits[i*LANE_BITS +: LANE_BITS], r_addend);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.launch) begin
          w_next = (bus.length == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ:  w_next = S_RD_DATA;
      S_RD_DATA: begin
        if (bus.mem_rd_valid && w_last_beat) w_next = S_WR_REQ;
      end
      S_WR_REQ:  w_next = S_WR_DATA;
      S_WR_DATA: begin
        if (w_last_beat) begin
          w_next = (r_remaining == HOST_DATA_BITS'(w_n)) ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_remaining <= '0;
      r_addend    <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.launch) begin
            r_remaining <= bus.length;
            r_addend    <= bus.addend[LANE_BITS-1:0];
            r_rd_ptr    <= bus.inp_baddr;
            r_wr_ptr    <= bus.out_baddr;
          end
        end
        S_RD_REQ, S_WR_REQ: r_cnt <= '0;
        S_RD_DATA: begin
          if (bus.mem_rd_valid) r_cnt <= r_cnt + CW'(1);
        end
        S_WR_DATA: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_last_beat) begin
            r_remaining <= r_remaining - HOST_DATA_BITS'(w_n);
            r_rd_ptr    <= r_rd_ptr + w_step;
            r_wr_ptr    <= r_wr_ptr + w_step;
          end
        end
        default: ;
      endcase
    end
  end

  // Burst buffer needs no reset; it is always filled before it is read.
  always_ff @(posedge clock) begin
    if (w_rd_fire) r_buf[w_idx] <= w_sum;
  end

  always_comb begin
    bus.finish         = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_opcode = 1'b0;
    bus.mem_req_len    = '0;
    bus.mem_req_addr   = '0;
    bus.mem_wr_valid   = 1'b0;
    bus.mem_wr_bits    = '0;
    bus.mem_rd_ready   = 1'b0;
    unique case (r_state)
      S_RD_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_len   = MEM_LEN_BITS'(w_last);
        bus.mem_req_addr  = r_rd_ptr;
      end
      S_RD_DATA: bus.mem_rd_ready = 1'b1;
      S_WR_REQ: begin
        bus.mem_req_valid  = 1'b1;
        bus.mem_req_opcode = 1'b1;
        bus.mem_req_len    = MEM_LEN_BITS'(w_last);
        bus.mem_req_addr   = r_wr_ptr;
      end
      S_WR_DATA: begin
        bus.mem_wr_valid = 1'b1;
        bus.mem_wr_bits  = r_buf[w_idx];
      end
      S_DONE:  bus.finish = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_burst_vector_compute.sv
// Randomised directed bench for burst_vector_compute with a memory model
// and a word-level reference of the expected requests and write data.
module tb_burst_vector_compute;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  burst_vector_compute_if #(
    .MEM_LEN_BITS(8), .MEM_ADDR_BITS(64),
    .MEM_DATA_BITS(64), .HOST_DATA_BITS(32)
  ) bus ();

  burst_vector_compute #(
    .MEM_LEN_BITS(8), .MEM_ADDR_BITS(64), .MEM_DATA_BITS(64),
    .HOST_DATA_BITS(32), .LANE_BITS(8), .BURST_BEATS(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic        op;
    logic [7:0]  len;
    logic [63:0] addr;
  } req_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] src [$];
  logic [63:0] last_wdata;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {bus.finish, bus.mem_req_valid, bus.mem_req_opcode,
          bus.mem_req_len, bus.mem_wr_valid, bus.mem_rd_ready}, '0);
    check({tag, "_addr"}, bus.mem_req_addr, '0);
    check({tag, "_wbits"}, bus.mem_wr_bits, '0);
  endtask

  function automatic logic [63:0] ref_word(input logic [63:0] w,
                                           input logic [7:0] add);
    logic [63:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      s = int'(w[i*8 +: 8]) + int'(add);
`ifdef BURST_VECTOR_SAT_EN
      if (s > 255) s = 255;
`else
      s = s % 256;
`endif
      r[i*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  task automatic run_job(input string name, input int len,
                         input logic [7:0] add, input logic [63:0] inp,
                         input logic [63:0] outb, input int stall,
                         input bit relaunch, input int rst_at);
    req_t        exp_q [$];
    req_t        got;
    int          rem, n, cyc, fin, wr_total, wr_k, rd_left, rd_idx;
    int          rd_base, wr_base, last_rd, last_wr, wr_req_cyc;
    int          done_cyc, jj;
    logic [63:0] ra, wa;
    logic [31:0] r32;
    while (src.size() < len) src.push_back({$urandom(), $urandom()});
    rem = len; ra = inp; wa = outb;
    while (rem > 0) begin
      n = (rem < 8) ? rem : 8;
      exp_q.push_back(req_t'{1'b0, 8'(n - 1), ra});
      exp_q.push_back(req_t'{1'b1, 8'(n - 1), wa});
      ra += 64'(8 * n);
      wa += 64'(8 * n);
      rem -= n;
    end
    fin = 0; wr_total = 0; wr_k = 0; rd_left = 0; rd_idx = 0;
    rd_base = 0; wr_base = 0; last_rd = 0; last_wr = 0;
    wr_req_cyc = 0; done_cyc = -1;

    @(negedge clock);
    r32 = $urandom();
    bus.launch    = 1'b1;
    bus.length    = len;
    bus.addend    = {r32[31:8], add};
    bus.inp_baddr = inp;
    bus.out_baddr = outb;
    @(negedge clock);
    bus.launch    = 1'b0;
    bus.length    = $urandom();
    bus.addend    = $urandom();
    bus.inp_baddr = {$urandom(), $urandom()};
    bus.out_baddr = {$urandom(), $urandom()};

    for (cyc = 1; cyc < 400; cyc++) begin
      if (cyc > 1) @(negedge clock);
      if (bus.mem_req_valid) begin
        got = req_t'{bus.mem_req_opcode, bus.mem_req_len, bus.mem_req_addr};
        check({name, "_req_expected"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check({name, "_req"}, got, exp_q.pop_front());
        if (!got.op) begin
          check({name, "_rd_req_cyc"}, cyc, (last_wr == 0) ? 1 : last_wr + 1);
          rd_left = int'(got.len) + 1;
          rd_idx  = 0;
          rd_base = int'((got.addr - inp) >> 3);
        end else begin
          check({name, "_wr_req_cyc"}, cyc, last_rd + 1);
          wr_req_cyc = cyc;
          wr_k       = 0;
          wr_base    = int'((got.addr - outb) >> 3);
        end
      end
      if (bus.mem_wr_valid) begin
        jj = wr_base + wr_k;
        check({name, "_wr_in_range"}, (jj >= 0) && (jj < len), 1'b1);
        if (jj >= 0 && jj < len)
          check({name, "_wr_data"}, bus.mem_wr_bits, ref_word(src[jj], add));
        check({name, "_wr_cyc"}, cyc, wr_req_cyc + 1 + wr_k);
        last_wdata = bus.mem_wr_bits;
        wr_k++; wr_total++; last_wr = cyc;
      end else begin
        check({name, "_wr_bits_idle"}, bus.mem_wr_bits, '0);
      end
      if (bus.finish) begin
        fin++;
        check({name, "_fin_cyc"}, cyc, (len == 0) ? 1 : last_wr + 1);
        done_cyc = cyc;
      end
      if (cyc == rst_at) begin
        reset = 1'b1;
        #1;
        check_idle({name, "_rst_now"});
        bus.mem_rd_valid = 1'b0;
        @(negedge clock);
        check_idle({name, "_rst_hold"});
        reset = 1'b0;
        break;
      end
      if (rd_left > 0 && (stall == 0 || (stall == 1 && cyc % 2 == 0) ||
          (stall == 2 && $urandom_range(0, 2) != 0))) begin
        jj = rd_base + rd_idx;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_bits  = (jj >= 0 && jj < src.size()) ? src[jj]
                                                        : {$urandom(), $urandom()};
        if (bus.mem_rd_ready) begin
          rd_idx++; rd_left--; last_rd = cyc;
        end
      end else begin
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_bits  = {$urandom(), $urandom()};
      end
      bus.launch = relaunch && (cyc == 4);
      if (bus.launch) bus.length = 32'($urandom_range(1, 50));
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    bus.mem_rd_valid = 1'b0;
    bus.launch       = 1'b0;
    if (rst_at > 0) begin
      repeat (4) begin
        @(negedge clock);
        check({name, "_post_rst_quiet"},
              {bus.finish, bus.mem_req_valid, bus.mem_wr_valid}, '0);
      end
      check({name, "_no_finish"}, fin, 0);
    end else begin
      check({name, "_finish_count"}, fin, 1);
      check({name, "_reqs_left"}, exp_q.size(), 0);
      check({name, "_wr_beats"}, wr_total, len);
    end
    src.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b;
    bus.launch = 1'b0; bus.length = '0; bus.addend = '0;
    bus.inp_baddr = '0; bus.out_baddr = '0;
    bus.mem_rd_valid = 1'b0; bus.mem_rd_bits = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_idle("reset_state");
    reset = 1'b0;
    @(negedge clock);
    check_idle("idle_state");

    src.push_back(64'h0706050403020100);
    run_job("single", 1, 8'd1, 64'h2000, 64'h8000, 0, 1'b0, 0);
    check("single_const", last_wdata, 64'h0807060504030201);

    run_job("split", 20, 8'($urandom()), 64'h1000, 64'h40000, 0, 1'b0, 0);

    src.push_back(64'hFF00FF00FF00FF00);
    run_job("ovf", 1, 8'd1, 64'h3000, 64'h9000, 0, 1'b0, 0);
`ifdef BURST_VECTOR_SAT_EN
    check("ovf_const", last_wdata, 64'hFF01FF01FF01FF01);
`else
    check("ovf_const", last_wdata, 64'h0001000100010001);
`endif

    run_job("empty", 0, 8'd5, 64'h100, 64'h200, 0, 1'b0, 0);
    run_job("stall", 8, 8'($urandom()), 64'h5000, 64'h6000, 1, 1'b1, 0);
    run_job("rst", 16, 8'd3, 64'h7000, 64'hA000, 0, 1'b0, 4);
    run_job("after_rst", 1, 8'($urandom()), 64'h7100, 64'hA100, 0, 1'b0, 0);
    run_job("wrap", 10, 8'($urandom()), 64'hFFFF_FFFF_FFFF_FFE8,
            64'hFFFF_FFFF_FFFF_FFC0, 2, 1'b0, 0);

    for (int t = 0; t < 6; t++) begin
      a = {$urandom(), $urandom()} & ~64'h7;
      b = {$urandom(), $urandom()} & ~64'h7;
      run_job("rand", int'($urandom_range(1, 40)), 8'($urandom()), a, b,
              2, 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/burst_vector_compute.md
# burst_vector_compute

Parametrised successor to the single-lane add-by-one compute engine: streams `length` memory words from `inp_baddr`, adds a runtime `addend` independently to each of `MEM_DATA_BITS/LANE_BITS` lanes per word, and writes the results to `out_baddr`. Transfers use multi-beat bursts of up to `BURST_BEATS` words through an internal burst buffer. The block sits between the host register file (launch/finish/length/addresses/addend) and the memory DPI port.

## Interface
- `MEM_LEN_BITS`, 8: width of the burst length field; the field carries beats-1.
- `MEM_ADDR_BITS`, 64: memory byte-address width.
- `MEM_DATA_BITS`, 64: memory word width.
- `HOST_DATA_BITS`, 32: width of `length` and `addend`.
- `LANE_BITS`, 8: lane width. Must divide `MEM_DATA_BITS`.
- `BURST_BEATS`, 8: maximum beats per burst. Power of 2, ≤ 2^MEM_LEN_BITS.

Ports:
- `clock`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `launch`  in  1  start pulse; sampled only in IDLE.
- `finish`  out  1  one-cycle completion pulse.
- `length`  in  HOST_DATA_BITS  word count; sampled at launch.
- `addend`  in  HOST_DATA_BITS  low `LANE_BITS` bits are added per lane; sampled at launch.
- `inp_baddr`, `out_baddr`  in  MEM_ADDR_BITS  source and destination byte base addresses; sampled at launch.
- `mem_req_valid`  out  1  request strobe; always accepted in its cycle.
- `mem_req_opcode`  out  1  0 = read, 1 = write.
- `mem_req_len`  out  MEM_LEN_BITS  beats-1.
- `mem_req_addr`  out  MEM_ADDR_BITS  burst byte address.
- `mem_wr_valid`  out  1  write beat strobe; no backpressure.
- `mem_wr_bits`  out  MEM_DATA_BITS  write data.
- `mem_rd_valid`  in  1  read beat available.
- `mem_rd_bits`  in  MEM_DATA_BITS  read data.
- `mem_rd_ready`  out  1  read beat accepted when high together with `mem_rd_valid`.

## Operation
- **FSM states:** IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE.
- **IDLE:** on `launch`, latch `length`, `addend`, and both base addresses; `remaining` := `length`. Go to DONE if `length` == 0, otherwise go to RD_REQ. `launch` outside IDLE is ignored.
- **Burst size:** n = min(`remaining`, `BURST_BEATS`), fixed per burst.
- **RD_REQ:** for one cycle, `mem_req_valid`=1, opcode 0, len n-1, address = current read pointer. Then go to RD_DATA.
- **RD_DATA:**
  - `mem_rd_ready`=1 for the whole state.
  - Each accepted beat k is stored as buf[k] = lane-wise sum.
  - Lane i uses bits [i*LANE_BITS +: LANE_BITS]. Sums are modulo 2^LANE_BITS with no carry between lanes.
  - After the n-th accepted beat, go to WR_REQ.
- **WR_REQ:** for one cycle, `mem_req_valid`=1, opcode 1, len n-1, address = current write pointer.
- **WR_DATA:**
  - `mem_wr_valid`=1 for exactly n consecutive cycles, emitting buf[0..n-1] in order.
  - Then subtract n from `remaining` and advance both pointers by n*(MEM_DATA_BITS/8), wrapping modulo 2^MEM_ADDR_BITS.
  - If `remaining` is now 0, go to DONE; otherwise go to RD_REQ.
- **DONE:** `finish`=1 for one cycle, then go to IDLE.
- **Reset:** asynchronous reset in any state forces IDLE and clears counters and pointers. In-flight bursts are abandoned and no `finish` is produced.

## Timing
- **Reset values:** every output is 0 while `reset` is high and in IDLE. This covers `finish`, all `mem_req_*`, `mem_wr_valid`, `mem_wr_bits`, and `mem_rd_ready`.
- **Launch:** `launch` at cycle T gives `mem_req_valid` at T+1 (read). If `length`=0, `finish` is at T+1 instead.
- **Read handshake:** a beat transfers on any cycle where `mem_rd_valid` && `mem_rd_ready`. Gaps in `mem_rd_valid` stall RD_DATA indefinitely.
- **Write sequence:** last read beat at cycle R gives the write request at R+1 and write beats at R+2 .. R+1+n. The next read request, or `finish`, follows at R+2+n.
- **Output timing:** all outputs are registered or decoded from state only; no combinational path from inputs to outputs. `mem_wr_bits` is valid only while `mem_wr_valid`=1 and is 0 otherwise.
- **Register widths:** `remaining` is HOST_DATA_BITS wide. The beat counter is clog2(BURST_BEATS)+1 bits wide.

## Configuration
- **`BURST_VECTOR_SAT_EN` defined:** lane addition saturates. Any result ≥ 2^LANE_BITS becomes 2^LANE_BITS-1.
- **Not defined:** lane addition wraps modulo 2^LANE_BITS.
- Neither setting affects the interface or timing.

## Test plan
All scenarios use default parameters (8 lanes, `BURST_BEATS`=8).
- **Single word:** `length`=1, `addend`=1, read 0x0706050403020100 → one read request (len 0), one write request (len 0, addr=`out_baddr`), write 0x0807060504030201, one `finish` pulse.
- **Burst split:** `length`=20, `inp_baddr`=0x1000 → read requests at 0x1000/0x1040/0x1080 with len 7/7/3; writes mirror these from `out_baddr`; 20 write beats total; one `finish`.
- **Lane overflow:** `addend`=1 on 0xFF00FF00FF00FF00 → 0x0001000100010001 without the macro, 0xFF01FF01FF01FF01 with `BURST_VECTOR_SAT_EN`.
- **Empty job:** `length`=0 → `finish` at T+1, `mem_req_valid` never asserted.
- **Read stalls and ignored launch:** `length`=8 with `mem_rd_valid` toggling every other cycle, and `launch` re-pulsed mid-job → data correct and in order, exactly one job runs, one `finish`.
- **Reset mid-job:** `reset` asserted during RD_DATA of a `length`=16 job → all outputs 0 immediately with no `finish`. After release, `launch` with `length`=1 completes normally.
